sparc_ifu_waittrk: RTL
======================

SPARC_IFU_WAITTRK -- requirements
Module: sparc_ifu_waittrk

Interface
REQ-001 Parameter NTHR, default 4, number of hardware threads tracked (1..8).
REQ-002 Parameter TO_W, default 10, width of per-thread wait-timeout counter and limit.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_l  input  1  reset, synchronous, active-low.
REQ-005 thr_active  input  NTHR  thread enabled mask.
REQ-006 rst_thread  input  NTHR  per-thread reset request, forces OTHER wait.
REQ-007 set_imiss / clr_imiss  input  NTHR each  I$ miss wait set / ready.
REQ-008 set_other / clr_other  input  NTHR each  long-latency op wait set / ready.
REQ-009 set_stb / clr_stb  input  NTHR each  store-buffer wait set / retry.
REQ-010 dyser_stallreq  input  NTHR  per-thread DySER stall request, level.
REQ-011 to_limit  input  TO_W  timeout threshold in cycles; 0 disables timeout.
REQ-012 completion  output  NTHR  one-cycle wake pulse per thread.
REQ-013 wm_imiss, wm_other, wm_stb, wm_dyser  output  NTHR each  registered wait-state bits.
REQ-014 wait_to  output  NTHR  sticky timeout flag per thread.

Function
REQ-015 Per thread, four independent wait bits SHALL be held: IMISS, OTHER, STB, DYSER.
REQ-016 IMISS next = set_imiss | (wm_imiss & ~clr_imiss); set wins over simultaneous clear.
REQ-017 OTHER next = ((set_other & thr_active) | rst_thread | (wm_other & thr_active & ~clr_other)); rst_thread sets regardless of thr_active.
REQ-018 STB next = set_stb | (wm_stb & ~clr_stb).
REQ-019 A registered copy dys_q of dyser_stallreq SHALL be kept per thread; dys_clr = dys_q & ~dyser_stallreq (falling edge).
REQ-020 DYSER next = (dyser_stallreq & thr_active) | (wm_dyser & thr_active & ~dys_clr).
REQ-021 Thread deactivation (thr_active=0) SHALL clear OTHER and DYSER the next cycle; IMISS and STB unaffected.
REQ-022 completion[t] SHALL be combinational, same cycle as the clearing input: asserted iff at least one of wm_imiss/wm_other/wm_stb/wm_dyser is 1 and, for every set bit, its clear condition (clr_imiss, clr_other, clr_stb, dys_clr) is 1 this cycle.
REQ-023 completion[t] SHALL be 0 if any corresponding set_* or rst_thread is asserted in the same cycle (set-wins re-entry).
REQ-024 completion SHALL never assert for a thread with all four wait bits 0, even if clear inputs pulse.
REQ-025 Clear inputs for a bit not set SHALL be ignored (no effect on completion qualification beyond REQ-022).
REQ-026 Per-thread counter to_cnt (TO_W bits): increments each cycle any wait bit is 1; resets to 0 when all wait bits are 0 next cycle or on completion; saturates at all-ones.
REQ-027 wait_to[t] SHALL set the cycle after to_cnt == to_limit with to_limit != 0; it remains set until completion[t] or rst_thread[t], then clears next cycle.
REQ-028 to_limit change mid-wait SHALL take effect immediately on the compare; no retroactive flag if count already passed it.
REQ-029 All per-thread logic SHALL be independent; simultaneous events on different threads SHALL not interact.

Reset
REQ-030 rst_l=0 at a clock edge SHALL clear all wait bits, dys_q, to_cnt, and wait_to to 0.
REQ-031 During reset completion SHALL be 0; reset asserted mid-wait SHALL drop the wait without generating completion.
REQ-032 First cycle after rst_l rises, logic SHALL respond to inputs normally; a dyser_stallreq high at that time sets DYSER without a spurious dys_clr.

Verification
REQ-033 NTHR=4: set_imiss[1] cycle 0, set_other[1] cycle 2, clr_imiss[1] cycle 5 -> no completion; clr_other[1] cycle 8 -> completion=4'b0010 cycle 8 only, wm_* all 0 cycle 9.
REQ-034 dyser_stallreq[2] high cycles 1-6, thr_active=4'hF -> wm_dyser[2]=1 cycles 2-7, completion[2]=1 in cycle 7 only.
REQ-035 set_stb[0] and clr_stb[0] same cycle while wm_stb[0]=1 -> wm_stb[0] stays 1, completion[0]=0.
REQ-036 to_limit=5, set_other[3] cycle 0, no clear -> wait_to[3]=1 from cycle 7; clr_other[3] cycle 12 -> completion[3]=1 cycle 12, wait_to[3]=0 cycle 13.
REQ-037 rst_thread[0] with thr_active[0]=0 -> wm_other[0]=1 next cycle; then clr_other[0] with thr_active[0]=1 -> completion[0]=1.
REQ-038 Waits pending on threads 0-3, rst_l=0 one cycle -> all outputs 0, no completion pulse, counters restart at 0.

Source files
------------

// File: rtl/sparc_ifu_waittrk.sv
// Per-thread wait tracking: four wait reasons, a wake pulse when every pending
// reason is released, and a per-thread wait-timeout counter with a sticky flag.
module sparc_ifu_waittrk #(
    parameter int NTHR = 4,
    parameter int TO_W = 10
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic [NTHR-1:0] thr_active,
    input  logic [NTHR-1:0] rst_thread,
    input  logic [NTHR-1:0] set_imiss,
    input  logic [NTHR-1:0] clr_imiss,
    input  logic [NTHR-1:0] set_other,
    input  logic [NTHR-1:0] clr_other,
    input  logic [NTHR-1:0] set_stb,
    input  logic [NTHR-1:0] clr_stb,
    input  logic [NTHR-1:0] dyser_stallreq,
    input  logic [TO_W-1:0] to_limit,
    output logic [NTHR-1:0] completion,
    output logic [NTHR-1:0] wm_imiss,
    output logic [NTHR-1:0] wm_other,
    output logic [NTHR-1:0] wm_stb,
    output logic [NTHR-1:0] wm_dyser,
    output logic [NTHR-1:0] wait_to
);

    logic [NTHR-1:0] r_imiss;
    logic [NTHR-1:0] r_other;
    logic [NTHR-1:0] r_stb;
    logic [NTHR-1:0] r_dyser;
    logic [NTHR-1:0] r_dys_q;
    logic [NTHR-1:0] r_wait_to;
    logic [TO_W-1:0] r_to_cnt [NTHR];

    logic [NTHR-1:0] w_dys_clr;
    logic [NTHR-1:0] w_any_wait;
    logic [NTHR-1:0] w_all_clr;
    logic [NTHR-1:0] w_set_any;
    logic [NTHR-1:0] w_to_hit;
    logic [NTHR-1:0] w_completion;

    assign w_dys_clr  = r_dys_q & ~dyser_stallreq;
    assign w_any_wait = r_imiss | r_other | r_stb | r_dyser;
    assign w_all_clr  = (~r_imiss | clr_imiss) & (~r_other | clr_other)
                      & (~r_stb | clr_stb) & (~r_dyser | w_dys_clr);
    // A new wait arriving in the release cycle suppresses the wake.
    assign w_set_any  = set_imiss | set_other | set_stb | rst_thread;
    assign w_completion = {NTHR{rst_l}} & w_any_wait & w_all_clr & ~w_set_any;

    always_comb begin
        w_to_hit = '0;
        for (int t = 0; t < NTHR; t++) begin
            w_to_hit[t] = (to_limit != '0) && (r_to_cnt[t] == to_limit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_imiss   <= '0;
            r_other   <= '0;
            r_stb     <= '0;
            r_dyser   <= '0;
            r_dys_q   <= '0;
            r_wait_to <= '0;
            for (int t = 0; t < NTHR; t++) begin
                r_to_cnt[t] <= '0;
            end
        end else begin
            r_imiss <= set_imiss | (r_imiss & ~clr_imiss);
            r_other <= (set_other & thr_active) | rst_thread
                     | (r_other & thr_active & ~clr_other);
            r_stb   <= set_stb | (r_stb & ~clr_stb);
            r_dyser <= (dyser_stallreq & thr_active)
                     | (r_dyser & thr_active & ~w_dys_clr);
            r_dys_q <= dyser_stallreq;
            r_wait_to <= ~(w_completion | rst_thread) & (r_wait_to | w_to_hit);
            for (int t = 0; t < NTHR; t++) begin
                if (w_completion[t] || !w_any_wait[t]) begin
                    r_to_cnt[t] <= '0;
                end else if (r_to_cnt[t] != '1) begin
                    r_to_cnt[t] <= r_to_cnt[t] + TO_W'(1);
                end
            end
        end
    end

    assign completion = w_completion;
    assign wm_imiss   = r_imiss;
    assign wm_other   = r_other;
    assign wm_stb     = r_stb;
    assign wm_dyser   = r_dyser;
    assign wait_to    = r_wait_to;

endmodule
